usb_spiflash_responder: RTL
===========================

Name: usb_spiflash_responder

Overview:
- SPI-slave model of a serial NOR flash device; it is the device end of the bus that the DFU flash bridge drives.
- Decodes the command subset the bridge issues: 06, 04, 05, 03, 0B, 02, 20 and AB.
- Backs device contents with an external byte-wide synchronous RAM.
- Used as the flash target in system simulation and on FPGA loopback test boards.

Parameters:
- ADDR_BITS, 20: width of the byte address into the backing memory. Upper command-address bits are ignored.
- PAGE_SIZE, 256: program wrap boundary in bytes (power of 2).
- SECTOR_SIZE, 4096: erase granule in bytes (power of 2).
- PROG_CYCLES, 64: clk cycles BUSY stays high after a page program commits.
- ERASE_CYCLES, 256: clk cycles BUSY stays high after the sector fill completes.

Ports:
- clk  in  1  system clock. Must be at least 8x the SCK frequency.
- reset  in  1  asynchronous, active-low reset.
- spi_csel  in  1  chip select, active low.
- spi_clk  in  1  SCK, mode 0.
- spi_mosi  in  1  serial data from the bus master.
- spi_miso  out  1  serial data to the bus master.
- mem_addr  out  ADDR_BITS  backing-memory byte address.
- mem_rd_data  in  8  backing-memory read data, valid 1 clk after mem_addr.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wr_data  out  8  backing-memory write data.
- busy  out  1  mirrors SR1 bit0 (BUSY).
- wel  out  1  mirrors SR1 bit1 (WEL).
- last_cmd  out  8  opcode of the most recent complete command byte.

Behaviour:
- Reset (reset=0): all outputs 0, including spi_miso, mem_addr, mem_wr_en, busy, wel and last_cmd. FSM goes to IDLE. Asynchronous assert, synchronous deassert.
- Synchronisation:
  - spi_csel, spi_clk and spi_mosi each pass through 2 flops.
  - SCK rising edge samples MOSI, MSB first. SCK falling edge shifts MISO.
  - spi_csel high (synchronised) forces FSM to IDLE on the next clk, discards any partial byte, and drives spi_miso=0.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, STATUS, IGNORE, ERASE_FILL, BUSY_WAIT.
- IDLE -> CMD when csel falls.
- CMD: after 8 bits, latch last_cmd and decode.
  - While busy=1, only 05 is honoured; every other opcode goes to IGNORE.
  - 06: set wel when csel rises. 04: clear wel when csel rises.
  - 05 -> STATUS. AB -> IGNORE (no effect). Unknown opcode -> IGNORE.
  - 03, 0B, 02, 20 -> ADDR.
- ADDR: 24 bits, MSB first. Low ADDR_BITS are kept as the working address.
  - 03 -> RDATA. 0B -> DUMMY (8 bits, MISO=0) -> RDATA. 02 -> WDATA.
  - 20 -> IGNORE, with erase armed if wel=1.
- RDATA:
  - On the 8th bit of the address (or dummy) byte, drive mem_addr with the working address and increment it.
  - Load the returned byte into the MISO shifter before the next SCK falling edge. Its bit7 is presented immediately on that falling edge.
  - Prefetch the next byte each time a byte starts shifting.
  - Address wraps modulo 2^ADDR_BITS.
- STATUS: shifts {6'b0, wel, busy} repeatedly until csel rises. The value is re-latched at each byte start.
- WDATA (wel=1):
  - Each complete byte issues mem_wr_en for 1 clk, with mem_wr_data = received byte at the working address.
  - The low log2(PAGE_SIZE) address bits increment and wrap within the page; upper bits are held.
  - Data is stored directly; AND-programming is not modelled.
  - WDATA with wel=0: bytes are discarded and no strobe is issued.
- Commit on csel rise:
  - Program: if at least 1 byte was written, set busy, clear wel, enter BUSY_WAIT with a PROG_CYCLES countdown.
  - Erase: only if armed and all 32 bits were received. Set busy, clear wel, enter ERASE_FILL.
- ERASE_FILL: writes 8'hFF to every address of the sector (address aligned down to SECTOR_SIZE), one per clk, for SECTOR_SIZE cycles. Then BUSY_WAIT with an ERASE_CYCLES countdown.
- BUSY_WAIT: counter reaches 0 -> busy=0 -> IDLE.
  - SPI transactions during ERASE_FILL or BUSY_WAIT are decoded in parallel; only 05 responds.
  - ERASE_FILL owns mem_addr; RDATA is not reachable while busy.
- Aborted commands (csel rises mid-command or mid-address) have no side effects. wel is unchanged.

Test Plan:
- Bridge-style 03 read at address 0x000100, memory preloaded with 0x00..0xFF: MISO returns 0x00, 0x01 … 0x0F for 16 bytes; last_cmd=0x03.
- 0B fast read at 0x0000FE, 4 bytes, memory preloaded with 0x00..0xFF: dummy byte is ignored; returns 0xFE, 0xFF, 0x00, 0x01 (memory wrap is not triggered because ADDR_BITS covers the range).
- 06, then 02 at 0x0010F0 with 20 bytes 0xA0..0xB3: writes 0x10F0–0x10FF, then wraps to 0x1000–0x1003. busy=1 for 64 clks after csel rises; then wel=0.
- 06, then 20 at 0x002345: 4096 strobes writing 0xFF to 0x2000–0x2FFF. Repeated 05 polling reads 0x01 until done, then 0x00.
- 02 without a preceding 06: no mem_wr_en, busy stays 0. 06 followed by csel abort after 12 bits of the 02 address: wel stays 1, no write.
- reset pulsed low mid-RDATA: spi_miso=0, busy=0 and wel=0 immediately. The next 05 returns 0x00.

Source files
------------

// File: rtl/usb_spiflash_responder.sv
// SPI-slave model of a serial NOR flash, backed by an external byte RAM.
// Ports: clk/reset (async low); spi_csel/clk/mosi/miso (mode 0 bus);
//   mem_addr/mem_rd_data/mem_wr_en/mem_wr_data (sync RAM);
//   busy/wel (SR1 mirrors); last_cmd (last complete opcode).
module usb_spiflash_responder #(
   parameter int ADDR_BITS    = 20,
   parameter int PAGE_SIZE    = 256,
   parameter int SECTOR_SIZE  = 4096,
   parameter int PROG_CYCLES  = 64,
   parameter int ERASE_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spi_csel,
   input  logic                 spi_clk,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic [7:0]           mem_rd_data,
   output logic                 mem_wr_en,
   output logic [7:0]           mem_wr_data,
   output logic                 busy,
   output logic                 wel,
   output logic [7:0]           last_cmd
);
   localparam int AB = ADDR_BITS;
   localparam int PB = $clog2(PAGE_SIZE);
   localparam int SB = $clog2(SECTOR_SIZE);
   localparam int CW = $clog2(SECTOR_SIZE + ERASE_CYCLES + PROG_CYCLES + 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_CMD    = 4'd1;
   localparam logic [3:0] S_ADDR   = 4'd2;
   localparam logic [3:0] S_DUMMY  = 4'd3;
   localparam logic [3:0] S_RDATA  = 4'd4;
   localparam logic [3:0] S_WDATA  = 4'd5;
   localparam logic [3:0] S_STATUS = 4'd6;
   localparam logic [3:0] S_IGNORE = 4'd7;
   localparam logic [3:0] S_EFILL  = 4'd8;
   localparam logic [3:0] S_BWAIT  = 4'd9;

   logic [1:0]       r_cs_s, r_ck_s, r_mo_s;
   logic             r_cs_d, r_ck_d;
   logic [3:0]       r_state, r_bg;
   logic [4:0]       r_bits;
   logic [6:0]       r_sh;
   logic [7:0]       r_cmd, r_tx, r_rd_buf, r_wr_data;
   logic [AB-1:0]    r_addr, r_mem_addr;
   logic [AB-SB-1:0] r_base;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_fetch;
   logic             r_wr_en, r_miso, r_busy, r_wel;
   logic             r_set, r_clr, r_wrote, r_arm;

   logic             w_cs, w_ck, w_mo, w_rise, w_fall, w_cs_rise;
   logic [7:0]       w_byte, w_stat;
   logic [AB-1:0]    w_addr_nxt;
   logic [PB-1:0]    w_pg;

   assign w_cs       = r_cs_s[1];
   assign w_ck       = r_ck_s[1];
   assign w_mo       = r_mo_s[1];
   assign w_rise     = w_ck & ~r_ck_d;
   assign w_fall     = ~w_ck & r_ck_d;
   assign w_cs_rise  = w_cs & ~r_cs_d;
   assign w_byte     = {r_sh, w_mo};
   assign w_stat     = {6'b0, r_wel, r_busy};
   assign w_addr_nxt = {r_addr[AB-2:0], w_mo};
   assign w_pg       = r_addr[PB-1:0] + PB'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cs_s <= 2'b11; r_ck_s <= 2'b00; r_mo_s <= 2'b00;
         r_cs_d <= 1'b1;  r_ck_d <= 1'b0;
      end else begin
         r_cs_s <= {r_cs_s[0], spi_csel};
         r_ck_s <= {r_ck_s[0], spi_clk};
         r_mo_s <= {r_mo_s[0], spi_mosi};
         r_cs_d <= w_cs;
         r_ck_d <= w_ck;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE; r_bg <= S_IDLE; r_bits <= '0; r_sh <= '0;
         r_cmd <= '0; r_tx <= '0; r_rd_buf <= '0; r_wr_data <= '0;
         r_addr <= '0; r_mem_addr <= '0; r_base <= '0; r_cnt <= '0;
         r_fetch <= '0; r_wr_en <= 1'b0; r_miso <= 1'b0;
         r_busy <= 1'b0; r_wel <= 1'b0;
         r_set <= 1'b0; r_clr <= 1'b0; r_wrote <= 1'b0; r_arm <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         // RAM returns data one clk after it registers mem_addr
         r_fetch <= {r_fetch[0], 1'b0};
         if (r_fetch[1]) r_rd_buf <= mem_rd_data;
         case (r_bg)
            S_EFILL: begin
               r_wr_en    <= 1'b1;
               r_wr_data  <= 8'hFF;
               r_mem_addr <= {r_base, r_cnt[SB-1:0]};
               if (r_cnt == CW'(SECTOR_SIZE - 1)) begin
                  r_bg  <= S_BWAIT;
                  r_cnt <= CW'(ERASE_CYCLES - 1);
               end else r_cnt <= r_cnt + CW'(1);
            end
            S_BWAIT: begin
               if (r_cnt == '0) begin
                  r_busy <= 1'b0;
                  r_bg   <= S_IDLE;
               end else r_cnt <= r_cnt - CW'(1);
            end
            default: ;
         endcase
         if (w_cs) begin
            r_state <= S_IDLE; r_bits <= '0; r_miso <= 1'b0;
            r_set <= 1'b0; r_clr <= 1'b0; r_wrote <= 1'b0; r_arm <= 1'b0;
            if (w_cs_rise) begin
               if (r_wrote) begin
                  r_busy <= 1'b1; r_wel <= 1'b0; r_bg <= S_BWAIT;
                  r_cnt  <= CW'(PROG_CYCLES - 1);
               end else if (r_arm) begin
                  r_busy <= 1'b1; r_wel <= 1'b0; r_bg <= S_EFILL;
                  r_cnt  <= '0;   r_base <= r_addr[AB-1:SB];
               end else if (r_set) r_wel <= 1'b1;
               else if (r_clr) r_wel <= 1'b0;
            end
         end else begin
            if (r_state == S_IDLE) r_state <= S_CMD;
            if (w_fall) begin
               // bit count 0 on a falling edge marks a byte start
               if (r_state == S_RDATA && r_bits == '0) begin
                  r_tx       <= r_rd_buf;
                  r_miso     <= r_rd_buf[7];
                  r_mem_addr <= r_addr;
                  r_addr     <= r_addr + AB'(1);
                  r_fetch    <= {r_fetch[0], 1'b1};
               end else if (r_state == S_STATUS && r_bits == '0) begin
                  r_tx   <= w_stat;
                  r_miso <= w_stat[7];
               end else if (r_state == S_RDATA || r_state == S_STATUS) begin
                  r_tx   <= {r_tx[6:0], 1'b0};
                  r_miso <= r_tx[6];
               end else r_miso <= 1'b0;
            end
            if (w_rise) begin
               r_sh   <= w_byte[6:0];
               r_bits <= r_bits + 5'd1;
               case (r_state)
                  S_IDLE, S_CMD: begin
                     if (r_bits == 5'd7) begin
                        r_bits <= '0;
                        r_cmd  <= w_byte;
                        if (r_busy && w_byte != 8'h05) r_state <= S_IGNORE;
                        else begin
                           case (w_byte)
                              8'h06: begin r_set <= 1'b1; r_state <= S_IGNORE; end
                              8'h04: begin r_clr <= 1'b1; r_state <= S_IGNORE; end
                              8'h05: r_state <= S_STATUS;
                              8'h03, 8'h0B, 8'h02, 8'h20: r_state <= S_ADDR;
                              default: r_state <= S_IGNORE;
                           endcase
                        end
                     end
                  end
                  S_ADDR: begin
                     r_addr <= w_addr_nxt;
                     if (r_bits == 5'd23) begin
                        r_bits <= '0;
                        case (r_cmd)
                           8'h03: begin
                              r_mem_addr <= w_addr_nxt;
                              r_addr     <= w_addr_nxt + AB'(1);
                              r_fetch    <= {r_fetch[0], 1'b1};
                              r_state    <= S_RDATA;
                           end
                           8'h0B: r_state <= S_DUMMY;
                           8'h02: r_state <= S_WDATA;
                           default: begin
                              r_arm   <= r_wel;
                              r_state <= S_IGNORE;
                           end
                        endcase
                     end
                  end
                  S_DUMMY: begin
                     if (r_bits == 5'd7) begin
                        r_bits     <= '0;
                        r_mem_addr <= r_addr;
                        r_addr     <= r_addr + AB'(1);
                        r_fetch    <= {r_fetch[0], 1'b1};
                        r_state    <= S_RDATA;
                     end
                  end
                  S_RDATA, S_STATUS: if (r_bits == 5'd7) r_bits <= '0;
                  S_WDATA: begin
                     if (r_bits == 5'd7) begin
                        r_bits <= '0;
                        if (r_wel) begin
                           r_wr_en    <= 1'b1;
                           r_wr_data  <= w_byte;
                           r_mem_addr <= r_addr;
                           r_addr     <= {r_addr[AB-1:PB], w_pg};
                           r_wrote    <= 1'b1;
                        end
                     end
                  end
                  default: r_bits <= '0;
               endcase
            end
         end
      end
   end

   assign spi_miso    = r_miso;
   assign mem_addr    = r_mem_addr;
   assign mem_wr_en   = r_wr_en;
   assign mem_wr_data = r_wr_data;
   assign busy        = r_busy;
   assign wel         = r_wel;
   assign last_cmd    = r_cmd;
endmodule
